// File: rtl/mac_pkg.sv
// Shared FP32 field layout, MAC stage counts and FP helpers for the MAC result path.
// Latency: none (declarations only). Backpressure: not applicable.
// Holds no logic beyond the is_nan() helper.
package mac_pkg;
    localparam int DataWidth       = 32;
    localparam int SIGN_BIT        = 31;
    localparam int EXP_MSB         = 30;
    localparam int EXP_LSB         = 23;
    localparam int MAN_MSB         = 22;
    localparam int MAN_LSB         = 0;
    localparam int MUL_STAGES      = 5;
    localparam int ADD_STAGES      = 7;
    localparam int PIPELINE_STAGES = MUL_STAGES + ADD_STAGES;

    function automatic logic is_nan(input logic [DataWidth-1:0] d);
        return (&d[EXP_MSB:EXP_LSB]) && (|d[MAN_MSB:MAN_LSB]);
    endfunction
endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes on full are ignored unless a pop happens in the same cycle.
module mac_result_fifo #(
    parameter int Depth     = 32,
    parameter int DataWidth = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DataWidth-1:0]         push_dat,
    input  logic                         pop,
    output logic [DataWidth-1:0]         head_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);
    localparam int AW = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 pop_ok;
    logic                 push_ok;

    // Equal low bits with differing MSB means the writer has lapped the reader.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/mac_result_collector.sv
// Captures non-NOP MAC results into a FWFT FIFO, flags drops and tile boundaries; RELU_EN zeroes negative results.
// Latency: one cycle from NOPIn=0 to DataValid. TileDone one cycle after the tile's last result.
// Backpressure: none toward the MAC; AlmostFull leaves room for in-flight results, excess pushes are dropped.
module mac_result_collector #(
    parameter int DataWidth       = mac_pkg::DataWidth,
    parameter int Depth           = 32,
    parameter int Pipeline_Stages = mac_pkg::PIPELINE_STAGES,
    parameter int ResultsPerTile  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         NOPIn,
    input  logic [DataWidth-1:0]         DataIn,
    output logic [DataWidth-1:0]         DataOut,
    output logic                         DataValid,
    input  logic                         DataReady,
    output logic [$clog2(Depth+1)-1:0]   Count,
    output logic                         AlmostFull,
    output logic                         Overflow,
    input  logic                         ClrOverflow,
    output logic                         TileDone
);
    import mac_pkg::*;

    localparam int TW = $clog2(ResultsPerTile + 1);

    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 drop;
    logic [DataWidth-1:0] store_dat;
    logic [TW-1:0]        tile_cnt;

    assign push_req  = !NOPIn;
    assign DataValid = !empty;
    assign pop       = DataValid && DataReady;
    assign drop      = push_req && full && !pop;

`ifdef RELU_EN
    // NaN passes through so upstream faults stay visible downstream.
    assign store_dat = (DataIn[SIGN_BIT] && !is_nan(DataIn)) ? '0 : DataIn;
`else
    assign store_dat = DataIn;
`endif

    assign AlmostFull = (32'(Count) >= 32'(Depth - Pipeline_Stages));

    mac_result_fifo #(
        .Depth     (Depth),
        .DataWidth (DataWidth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req && !drop),
        .push_dat (store_dat),
        .pop      (pop),
        .head_dat (DataOut),
        .full     (full),
        .empty    (empty),
        .count    (Count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Overflow <= 1'b0;
        end else if (drop) begin
            Overflow <= 1'b1;
        end else if (ClrOverflow) begin
            Overflow <= 1'b0;
        end
    end

    // Dropped words still advance the tile count: it follows the MAC stream, not the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt <= '0;
            TileDone <= 1'b0;
        end else begin
            TileDone <= 1'b0;
            if (push_req) begin
                if (tile_cnt == TW'(ResultsPerTile - 1)) begin
                    tile_cnt <= '0;
                    TileDone <= 1'b1;
                end else begin
                    tile_cnt <= tile_cnt + 1'b1;
                end
            end
        end
    end
endmodule
